qpsk_transmitter: RTL and testbench

- Self-contained QPSK baseband-to-IF transmitter driving a 14-bit parallel DAC.
- Generates PRBS-9 data internally, maps 2 bits per symbol to I/Q, holds each symbol for SPS samples with a rectangular pulse, and upconverts digitally at fs/4.
- Sits at the board top level: CLOCK_50 in, DAC data and DAC control pins out.

---
 rtl/qpsk_transmitter_if.sv | 29 ++
 rtl/qpsk_transmitter.sv | 91 +++++++++
 tb/tb_qpsk_transmitter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/qpsk_transmitter_if.sv
// qpsk_transmitter_if
// Groups the parallel DAC pins driven by the QPSK transmitter.
//   PLL_OUT_DA : DAC sample clock (inverted system clock)
//   DA_MODE    : DAC mode select, tied high
//   DA_WRTA    : DAC write strobe (same waveform as PLL_OUT_DA)
//   DAC_OUT    : offset-binary sample word, BIT_DAC bits
// Modports: master = transmitter side (drives), slave = DAC side (observes).
interface qpsk_transmitter_if #(
    parameter int BIT_DAC = 14
);
    logic               PLL_OUT_DA;
    logic               DA_MODE;
    logic               DA_WRTA;
    logic [BIT_DAC-1:0] DAC_OUT;

    modport master (
        output PLL_OUT_DA,
        output DA_MODE,
        output DA_WRTA,
        output DAC_OUT
    );

    modport slave (
        input PLL_OUT_DA,
        input DA_MODE,
        input DA_WRTA,
        input DAC_OUT
    );
endinterface

// File: rtl/qpsk_transmitter.sv
// qpsk_transmitter
// Self-contained QPSK transmitter: PRBS-9 source, 2 bits/symbol QPSK
// mapping, rectangular pulse of SPS samples per symbol, and digital
// upconversion at fs/4 onto a parallel offset-binary DAC.
// Ports:
//   CLOCK_50 : 50 MHz system / sample clock
//   SW       : asynchronous active-low reset (0 = reset)
//   dac      : DAC pin bundle (master modport)
// Parameters:
//   BIT_DAC  : DAC width (14 only)
//   SPS      : samples per symbol, 2..256
//   AMP      : symbol amplitude in LSBs, < 2^(BIT_DAC-1)
//   SEED     : nonzero PRBS reset value
module qpsk_transmitter #(
    parameter int         BIT_DAC = 14,
    parameter int         SPS     = 8,
    parameter int         AMP     = 4096,
    parameter logic [8:0] SEED    = 9'h1FF
) (
    input  logic               CLOCK_50,
    input  logic               SW,
    qpsk_transmitter_if.master dac
);

    localparam int                          CW       = $clog2(SPS);
    localparam logic [CW-1:0]               SYM_LAST = CW'(SPS - 1);
    localparam logic signed [BIT_DAC-1:0]   A_POS    = BIT_DAC'(AMP);
    localparam logic signed [BIT_DAC-1:0]   A_NEG    = BIT_DAC'(-AMP);
    localparam logic [BIT_DAC-1:0]          MIDSCALE = {1'b1, {(BIT_DAC-1){1'b0}}};

    logic [8:0]                lfsr;
    logic [CW-1:0]             sym_cnt;
    logic [1:0]                phase;
    logic [BIT_DAC-1:0]        dac_q;

    logic                      sym_end;
    logic [8:0]                lfsr_nxt;
    logic signed [BIT_DAC-1:0] s;
    logic [BIT_DAC-1:0]        dac_nxt;

    // One Fibonacci step of x^9 + x^5 + 1.
    function automatic logic [8:0] prbs_step(input logic [8:0] l);
        return {l[7:0], l[8] ^ l[4]};
    endfunction

    assign sym_end  = (sym_cnt == SYM_LAST);
    // Two bits are consumed per symbol, so the generator moves two steps
    // in the single cycle where the symbol boundary is crossed.
    assign lfsr_nxt = prbs_step(prbs_step(lfsr));

    // fs/4 mixer: cos/sin take only the values 0/+-1, so the upconverted
    // sample reduces to picking I, -Q, -I, Q in turn.
    always_comb begin
        s = A_POS;
        unique case (phase)
            2'd0:    s = lfsr[0] ? A_NEG : A_POS;   //  I
            2'd1:    s = lfsr[1] ? A_POS : A_NEG;   // -Q
            2'd2:    s = lfsr[0] ? A_POS : A_NEG;   // -I
            default: s = lfsr[1] ? A_NEG : A_POS;   //  Q
        endcase
    end

    // Two's complement to offset binary: flip the sign bit.
    assign dac_nxt = {~s[BIT_DAC-1], s[BIT_DAC-2:0]};

    always_ff @(posedge CLOCK_50 or negedge SW) begin
        if (!SW) begin
            lfsr    <= SEED;
            sym_cnt <= '0;
            phase   <= 2'd0;
            dac_q   <= MIDSCALE;
        end else begin
            phase <= phase + 2'd1;
            dac_q <= dac_nxt;
            if (sym_end) begin
                sym_cnt <= '0;
                lfsr    <= lfsr_nxt;
            end else begin
                sym_cnt <= sym_cnt + CW'(1);
            end
        end
    end

    // DAC latches on its clock's rising edge, half a cycle after DAC_OUT
    // changes, giving full half-period setup and hold. Runs through reset.
    assign dac.PLL_OUT_DA = ~CLOCK_50;
    assign dac.DA_WRTA    = ~CLOCK_50;
    assign dac.DA_MODE    = 1'b1;
    assign dac.DAC_OUT    = dac_q;

endmodule

// File: tb/tb_qpsk_transmitter.sv
// tb_qpsk_transmitter
// Directed bench for qpsk_transmitter: default build (SPS=8, AMP=4096) and
// a variant (SPS=4, AMP=1000) share clock and reset.
module tb_qpsk_transmitter;

    logic clk = 1'b0;
    logic sw  = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #10 clk = ~clk;

    qpsk_transmitter_if #(.BIT_DAC(14)) dac0 ();
    qpsk_transmitter_if #(.BIT_DAC(14)) dac1 ();

    qpsk_transmitter #(.BIT_DAC(14), .SPS(8), .AMP(4096), .SEED(9'h1FF)) dut0 (
        .CLOCK_50 (clk),
        .SW       (sw),
        .dac      (dac0)
    );

    qpsk_transmitter #(.BIT_DAC(14), .SPS(4), .AMP(1000), .SEED(9'h1FF)) dut1 (
        .CLOCK_50 (clk),
        .SW       (sw),
        .dac      (dac1)
    );

    // Hand-computed first two symbols of the default build.
    int first16 [16] = '{4096, 12288, 12288, 4096, 4096, 12288, 12288, 4096,
                         12288, 4096, 4096, 12288, 12288, 4096, 4096, 12288};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] prbs(input logic [8:0] l);
        return {l[7:0], l[8] ^ l[4]};
    endfunction

    function automatic int model_sample(input logic [8:0] l, input int ph, input int a);
        int i_v;
        int q_v;
        int s_v;
        i_v = l[0] ? -a : a;
        q_v = l[1] ? -a : a;
        case (ph)
            0:       s_v = i_v;
            1:       s_v = -q_v;
            2:       s_v = -i_v;
            default: s_v = q_v;
        endcase
        return 8192 + s_v;
    endfunction

    // Assumes reset was just released before a rising edge; sample k is read
    // on the falling edge after the (k+1)-th rising edge.
    task automatic run_samples(input int n);
        logic [8:0] l0;
        logic [8:0] l1;
        int         e0;
        int         e1;
        int         v0;
        int         v1;
        l0 = 9'h1FF;
        l1 = 9'h1FF;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            v0 = int'(dac0.DAC_OUT);
            v1 = int'(dac1.DAC_OUT);
            e0 = model_sample(l0, k % 4, 4096);
            e1 = model_sample(l1, k % 4, 1000);
            check("sps8_model", dac0.DAC_OUT, e0);
            check("sps4_model", dac1.DAC_OUT, e1);
            check("sps8_range", 32'((v0 == 4096) || (v0 == 12288)), 1);
            check("sps4_range", 32'((v1 == 7192) || (v1 == 9192)), 1);
            if (k < 16) check("sps8_table", dac0.DAC_OUT, first16[k]);
            if (k % 256 == 0) begin
                check("da_mode", dac0.DA_MODE, 1);
                check("pll_low_clk", dac0.PLL_OUT_DA, 1);
                check("wrta_low_clk", dac0.DA_WRTA, 1);
            end
            if (k % 8 == 7) l0 = prbs(prbs(l0));
            if (k % 4 == 3) l1 = prbs(prbs(l1));
        end
    endtask

    initial begin
        // Reset held
        sw = 1'b0;
        @(negedge clk);
        check("rst_dac0", dac0.DAC_OUT, 8192);
        check("rst_dac1", dac1.DAC_OUT, 8192);
        check("rst_mode", dac0.DA_MODE, 1);
        check("rst_pll_clk0", dac0.PLL_OUT_DA, 1);
        check("rst_wrta_clk0", dac0.DA_WRTA, 1);
        @(posedge clk);
        #1;
        check("rst_pll_clk1", dac0.PLL_OUT_DA, 0);
        check("rst_wrta_clk1", dac0.DA_WRTA, 0);
        check("rst_hold_dac0", dac0.DAC_OUT, 8192);

        // Release and run 2048 samples (256 symbols at SPS=8)
        @(negedge clk);
        sw = 1'b1;
        run_samples(2048);

        // Asynchronous reset mid-run, between clock edges
        @(posedge clk);
        #3;
        sw = 1'b0;
        #1;
        check("midrst_dac0", dac0.DAC_OUT, 8192);
        check("midrst_dac1", dac1.DAC_OUT, 8192);
        @(negedge clk);
        @(negedge clk);
        check("midrst_hold", dac0.DAC_OUT, 8192);
        sw = 1'b1;
        run_samples(32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
